// File: rtl/rsa_operand_sequencer.sv
// rtl/rsa_operand_sequencer.sv - frame controller between UART, serial_to_parallel and RSA core
module rsa_operand_sequencer #(
  parameter int          N       = 32,
  parameter int          TIMEOUT = 1000,
  parameter logic [7:0]  CMD_RUN = 8'hA5
) (
  input  logic         iCE_CLK,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  output logic         s2p_rx_valid,
  output logic [7:0]   s2p_rx_byte,
  output logic         s2p_clr,
  input  logic         s2p_valid,
  input  logic [N-1:0] s2p_word,
  output logic [N-1:0] core_msg,
  output logic [N-1:0] core_exp,
  output logic [N-1:0] core_mod,
  output logic         core_start,
  input  logic         core_done,
  input  logic [N-1:0] core_result,
  output logic         tx_start,
  output logic [7:0]   tx_byte,
  input  logic         tx_busy,
  output logic         busy,
  output logic         err
);

  localparam int NB = N / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LD_MSG, LD_EXP, LD_MOD, START, WAIT, TX_SEND, TX_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] idle_cnt;
  logic [IW-1:0] idx;
  logic          tx_first;
  logic [N-1:0]  result;
  logic          in_load;

  // Bytes reach serial_to_parallel only while an operand is being loaded.
  assign in_load      = (state == LD_MSG) || (state == LD_EXP) || (state == LD_MOD);
  assign s2p_rx_valid = in_load & rx_valid;
  assign s2p_rx_byte  = rx_byte;
  assign busy         = (state != IDLE);

  // Frame FSM: header decode, operand capture, core handshake and MSB-first result streaming.
  always_ff @(posedge iCE_CLK) begin
    if (rst) begin
      state      <= IDLE;
      idle_cnt   <= '0;
      idx        <= '0;
      tx_first   <= 1'b0;
      result     <= '0;
      core_msg   <= '0;
      core_exp   <= '0;
      core_mod   <= '0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      tx_byte    <= '0;
      s2p_clr    <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= 1'b0;
      s2p_clr    <= 1'b0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_byte == CMD_RUN) begin
              state    <= LD_MSG;
              idle_cnt <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LD_MSG, LD_EXP, LD_MOD: begin
          if (rx_valid) idle_cnt <= '0;
          else          idle_cnt <= idle_cnt + 1'b1;
          // A completed word takes priority over a coincident timeout.
          if (s2p_valid) begin
            case (state)
              LD_MSG: begin
                core_msg <= s2p_word;
                state    <= LD_EXP;
              end
              LD_EXP: begin
                core_exp <= s2p_word;
                state    <= LD_MOD;
              end
              default: begin
                core_mod   <= s2p_word;
                core_start <= 1'b1;
                state      <= START;
              end
            endcase
          end else if (!rx_valid && idle_cnt >= CW'(TIMEOUT - 1)) begin
            s2p_clr  <= 1'b1;
            err      <= 1'b1;
            idle_cnt <= '0;
            state    <= IDLE;
          end
        end
        START: begin
          if (rx_valid) err <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (rx_valid) err <= 1'b1;
          if (core_done) begin
            result <= core_result;
            idx    <= IW'(NB - 1);
            state  <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (rx_valid) err <= 1'b1;
          if (!tx_busy) begin
            tx_byte  <= result[N-1 -: 8];
            result   <= result << 8;
            tx_start <= 1'b1;
            tx_first <= 1'b1;
            state    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (rx_valid) err <= 1'b1;
          // The transmitter may not raise busy until after it sees tx_start.
          if (tx_first) begin
            tx_first <= 1'b0;
          end else if (!tx_busy) begin
            if (idx == '0) begin
              state <= IDLE;
            end else begin
              idx   <= idx - 1'b1;
              state <= TX_SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// tb/tb_rsa_operand_sequencer.sv - directed self-checking bench for rsa_operand_sequencer
module tb_rsa_operand_sequencer;

  localparam int N       = 32;
  localparam int TIMEOUT = 20;

  logic         iCE_CLK = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic         s2p_rx_valid;
  logic [7:0]   s2p_rx_byte;
  logic         s2p_clr;
  logic         s2p_valid;
  logic [N-1:0] s2p_word;
  logic [N-1:0] core_msg;
  logic [N-1:0] core_exp;
  logic [N-1:0] core_mod;
  logic         core_start;
  logic         core_done;
  logic [N-1:0] core_result;
  logic         tx_start;
  logic [7:0]   tx_byte;
  logic         tx_busy;
  logic         busy;
  logic         err;

  int vectors = 0;
  int miscompares = 0;

  int fwd_count;
  int byte_bad;
  logic start_seen;
  logic start_early;

  rsa_operand_sequencer #(.N(N), .TIMEOUT(TIMEOUT), .CMD_RUN(8'hA5)) dut (
    .iCE_CLK(iCE_CLK), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .s2p_rx_valid(s2p_rx_valid), .s2p_rx_byte(s2p_rx_byte), .s2p_clr(s2p_clr),
    .s2p_valid(s2p_valid), .s2p_word(s2p_word), .core_msg(core_msg),
    .core_exp(core_exp), .core_mod(core_mod), .core_start(core_start),
    .core_done(core_done), .core_result(core_result), .tx_start(tx_start),
    .tx_byte(tx_byte), .tx_busy(tx_busy), .busy(busy), .err(err)
  );

  always #5 iCE_CLK = ~iCE_CLK;

  task automatic tick;
    @(posedge iCE_CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    #1;
    if (s2p_rx_valid) begin
      fwd_count++;
      if (s2p_rx_byte !== b) byte_bad++;
    end
    if (core_start) start_early = 1'b1;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic load_word(input logic [N-1:0] w, input logic last);
    for (int i = N / 8 - 1; i >= 0; i--) send_byte(w[8*i +: 8]);
    if (core_start) start_early = 1'b1;
    s2p_valid = 1'b1;
    s2p_word  = w;
    tick;
    s2p_valid = 1'b0;
    if (last) start_seen = core_start;
    else if (core_start) start_early = 1'b1;
  endtask

  task automatic load_frame(input logic [N-1:0] m, input logic [N-1:0] e, input logic [N-1:0] md);
    fwd_count   = 0;
    byte_bad    = 0;
    start_seen  = 1'b0;
    start_early = 1'b0;
    send_byte(8'hA5);
    load_word(m, 1'b0);
    load_word(e, 1'b0);
    load_word(md, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; s2p_valid = 1'b0; s2p_word = '0;
    core_done = 1'b0; core_result = '0; tx_busy = 1'b0;
    tick; tick;
    rst = 1'b0;
    vectors++;
    if ({busy, err, core_start, tx_start, s2p_clr, s2p_rx_valid} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000", {busy, err, core_start, tx_start, s2p_clr, s2p_rx_valid});
    end
    vectors++;
    if ({core_msg, core_exp, core_mod, tx_byte} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h/%h/%h/%h expected all zero", core_msg, core_exp, core_mod, tx_byte);
    end
  endtask

  task automatic test_load;
    load_frame(32'h00000041, 32'h00000007, 32'h0000008F);
    vectors++;
    if ({core_msg, core_exp, core_mod} !== {32'h41, 32'h7, 32'h8F}) begin
      miscompares++;
      $display("FAIL load_operands: got %h %h %h expected 00000041 00000007 0000008f", core_msg, core_exp, core_mod);
    end
    vectors++;
    if (fwd_count !== 12 || byte_bad !== 0) begin
      miscompares++;
      $display("FAIL load_forward: got %0d forwarded %0d bad expected 12 forwarded 0 bad", fwd_count, byte_bad);
    end
    vectors++;
    if (start_seen !== 1'b1 || start_early !== 1'b0) begin
      miscompares++;
      $display("FAIL load_start_latency: got seen=%b early=%b expected seen=1 early=0", start_seen, start_early);
    end
    tick;
    vectors++;
    if (core_start !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL load_start_width: got start=%b busy=%b expected start=0 busy=1", core_start, busy);
    end
  endtask

  task automatic test_result_stream;
    logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic found;
    int bad_busy = 0;
    tx_busy = 1'b1;
    core_result = 32'hDEADBEEF;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
    core_result = '0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (tx_start) bad_busy++;
    end
    for (int i = 0; i < 4; i++) begin
      tx_busy = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        tick;
        found = tx_start;
      end
      vectors++;
      if (!found || tx_byte !== exp_b[i]) begin
        miscompares++;
        $display("FAIL tx_byte_%0d: got start=%b byte=%h expected start=1 byte=%h", i, found, tx_byte, exp_b[i]);
      end
      tx_busy = 1'b1;
      tick;
      vectors++;
      if (tx_start !== 1'b0) begin
        miscompares++;
        $display("FAIL tx_start_width_%0d: got %b expected 0", i, tx_start);
      end
      for (int k = 0; k < 2; k++) begin
        tick;
        if (tx_start) bad_busy++;
      end
    end
    tx_busy = 1'b0;
    tick;
    vectors++;
    if (bad_busy !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_done: got busy_starts=%0d busy=%b expected 0 and 0", bad_busy, busy);
    end
  endtask

  task automatic test_bad_header;
    rx_valid = 1'b1;
    rx_byte  = 8'h3C;
    #1;
    vectors++;
    if (s2p_rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL header_forward: got %b expected 0", s2p_rx_valid);
    end
    tick;
    rx_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL header_err: got err=%b busy=%b expected err=1 busy=0", err, busy);
    end
    tick;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL header_err_width: got %b expected 0", err);
    end
  endtask

  task automatic test_timeout;
    int early = 0;
    fwd_count = 0; byte_bad = 0;
    send_byte(8'hA5);
    send_byte(8'h11);
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      tick;
      if (err || s2p_clr) early++;
    end
    send_byte(8'h22);
    vectors++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_reload: got busy=%b err=%b expected busy=1 err=0", busy, err);
    end
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      tick;
      if (err || s2p_clr || !busy) early++;
    end
    tick;
    vectors++;
    if (early !== 0 || s2p_clr !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_abort: got early=%0d clr=%b err=%b busy=%b expected 0 1 1 0", early, s2p_clr, err, busy);
    end
    tick;
    vectors++;
    if (s2p_clr !== 1'b0 || err !== 1'b0 || core_msg !== 32'h41) begin
      miscompares++;
      $display("FAIL timeout_after: got clr=%b err=%b msg=%h expected 0 0 00000041", s2p_clr, err, core_msg);
    end
    load_frame(32'h12345678, 32'h00010001, 32'hCAFEF00D);
    vectors++;
    if ({core_msg, core_exp, core_mod} !== {32'h12345678, 32'h00010001, 32'hCAFEF00D} || start_seen !== 1'b1 || start_early !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_reload_frame: got %h %h %h start=%b early=%b expected 12345678 00010001 cafef00d 1 0",
               core_msg, core_exp, core_mod, start_seen, start_early);
    end
  endtask

  task automatic test_overrun;
    logic [7:0] exp_b [4] = '{8'h0B, 8'hAD, 8'hF0, 8'h0D};
    logic [7:0] got [4] = '{default: 8'h00};
    int n = 0;
    int stray = 0;
    tick;
    rx_valid = 1'b1;
    rx_byte  = 8'h55;
    #1;
    vectors++;
    if (s2p_rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_forward: got %b expected 0", s2p_rx_valid);
    end
    tick;
    rx_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_err: got err=%b busy=%b expected 1 1", err, busy);
    end
    tx_busy = 1'b0;
    core_result = 32'h0BADF00D;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
    for (int k = 0; k < 40 && busy; k++) begin
      tick;
      if (tx_start) begin
        if (n < 4) got[n] = tx_byte;
        n++;
      end
    end
    vectors++;
    if (n !== 4 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_count: got %0d bytes busy=%b expected 4 bytes busy=0", n, busy);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== exp_b[i]) begin
        miscompares++;
        $display("FAIL overrun_byte_%0d: got %h expected %h", i, got[i], exp_b[i]);
      end
    end
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (busy || tx_start) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL done_in_idle: got %0d active cycles expected 0", stray);
    end
  endtask

  task automatic test_reset_mid;
    int stray = 0;
    send_byte(8'hA5);
    load_word(32'hAAAA5555, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    vectors++;
    if (busy !== 1'b1 || core_msg !== 32'hAAAA5555) begin
      miscompares++;
      $display("FAIL midreset_setup: got busy=%b msg=%h expected 1 aaaa5555", busy, core_msg);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++;
    if ({busy, err, core_start, tx_start, s2p_clr} !== 5'b0 || {core_msg, core_exp, core_mod, tx_byte} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got flags=%b regs=%h/%h/%h/%h expected all zero",
               {busy, err, core_start, tx_start, s2p_clr}, core_msg, core_exp, core_mod, tx_byte);
    end
    s2p_valid = 1'b1;
    s2p_word  = 32'hFFFFFFFF;
    tick;
    s2p_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (core_start || busy || tx_start) stray++;
    end
    vectors++;
    if (stray !== 0 || core_msg !== '0 || core_exp !== '0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got stray=%0d msg=%h exp=%h expected 0 0 0", stray, core_msg, core_exp);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_result_stream;
    test_bad_header;
    test_timeout;
    test_overrun;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
